alu_seq_n: RTL

ALU_SEQ_N -- requirements
Module: alu_seq_n

---
 rtl/alu_pkg.sv | 27 ++
 rtl/mul_seq.sv | 48 ++++
 rtl/alu_seq_n.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
// Imported by both the RTL and the testbench.
package alu_pkg;

    localparam logic [3:0] OP_NOT_A = 4'b0000;
    localparam logic [3:0] OP_NOT_B = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_XNOR  = 4'b0101;
    localparam logic [3:0] OP_ADD   = 4'b0110;
    localparam logic [3:0] OP_SUB   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_SHL   = 4'b1001;
    localparam logic [3:0] OP_SHR   = 4'b1010;
    localparam logic [3:0] OP_ASR   = 4'b1011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Shift-and-add unsigned multiplier: one multiplier bit per i_step, WIDTH steps.
// o_prod_nxt is the product after the current step, so the caller can capture the final value on the last step.
module mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod_nxt,
    output logic               o_last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] w_addend;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign o_prod_nxt = r_prod + w_addend;
    // Asserted during the final step, i.e. the WIDTH-th multiplier bit.
    assign o_last     = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_prod   <= o_prod_nxt;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq_n.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus a multi-cycle unsigned multiply.
// Handshake: start/op/a/b are sampled on a rising edge only while busy=0; done pulses one cycle with result/flags valid.
module alu_seq_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v,
    output state_t           dbg_state
);

    localparam int SW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_single;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod_nxt;

    logic [WIDTH-1:0]   r_result;
    logic               r_done, r_c, r_n, r_z, r_v;

    logic [WIDTH:0]        w_add;
    logic [WIDTH:0]        w_sub;
    logic [WIDTH:0]        w_shl;
    logic [WIDTH:0]        w_shr;
    logic signed [WIDTH:0] w_asr;
    logic [SW-1:0]         w_amt;
    logic [WIDTH-1:0]      w_res;
    logic                  w_c;
    logic                  w_v;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_single    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul(op)) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_single    = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_a        (a),
        .i_b        (b),
        .o_prod_nxt (w_prod_nxt),
        .o_last     (w_last)
    );

    // One extra bit on each shift catches the last bit shifted out.
    assign w_amt = b[SW-1:0];
    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign w_shl = {1'b0, a} << w_amt;
    assign w_shr = {a, 1'b0} >> w_amt;
    assign w_asr = $signed({a, 1'b0}) >>> w_amt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            OP_NOT_A: w_res = ~a;
            OP_NOT_B: w_res = ~b;
            OP_AND:   w_res = a & b;
            OP_OR:    w_res = a | b;
            OP_XOR:   w_res = a ^ b;
            OP_XNOR:  w_res = ~(a ^ b);
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_ASR: begin
                w_res = w_asr[WIDTH:1];
                w_c   = w_asr[0];
            end
            default: begin
                w_res = '0;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
            r_done   <= 1'b0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_single) begin
                r_result <= w_res;
                r_c      <= w_c;
                r_v      <= w_v;
                r_n      <= w_res[WIDTH-1];
                r_z      <= ~|w_res;
                r_done   <= 1'b1;
            end else if (w_step && w_last) begin
                r_result <= w_prod_nxt[WIDTH-1:0];
                r_c      <= 1'b0;
                r_v      <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                r_n      <= w_prod_nxt[WIDTH-1];
                r_z      <= ~|w_prod_nxt[WIDTH-1:0];
                r_done   <= 1'b1;
            end
        end
    end

    assign busy      = (r_state == ST_MUL);
    assign done      = r_done;
    assign result    = r_result;
    assign c         = r_c;
    assign n         = r_n;
    assign z         = r_z;
    assign v         = r_v;
    assign dbg_state = r_state;

endmodule
